token_ring_ctrl_mc: RTL

//  Next-generation token-ring router control FSM. Arbitrates NUM_CH node-side request channels round-robin

---
 rtl/token_ring_ctrl_mc.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/token_ring_ctrl_mc.sv
// token_ring_ctrl_mc: token-ring router control FSM. It arbitrates node
// channels round-robin while holding the token, retries NACKed packets, times
// out missing ACKs, and regenerates a lost token on the ring master.
// Ports:
//   Clk_R, Rst (sync, active-high)
//   rx side: rx_has_data, data_type, address, bad_decode -> rc_ready
//   tx side: tx_ready -> tx_data_select, rc_has_data, ch_select
//   node side: Packet_From_Node_Valid -> Core_Load_Ack, Packet_To_Node_Valid
//   status pulses: retry_fail, token_lost
module token_ring_ctrl_mc #(
   parameter int NUM_CH        = 4,
   parameter int ADDR_W        = 4,
   parameter int OUR_ADDRESS   = 1,
   parameter int MAX_RETRY     = 3,
   parameter int ACK_TIMEOUT   = 255,
   parameter int TOKEN_TIMEOUT = 4095,
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              Clk_R,
   input  logic              Rst,
   input  logic              rx_has_data,
   input  logic [2:0]        data_type,
   input  logic [ADDR_W-1:0] address,
   input  logic              bad_decode,
   input  logic              tx_ready,
   input  logic [NUM_CH-1:0] Packet_From_Node_Valid,
   output logic [NUM_CH-1:0] Core_Load_Ack,
   output logic [CH_W-1:0]   ch_select,
   output logic [2:0]        tx_data_select,
   output logic              rc_has_data,
   output logic              rc_ready,
   output logic              Packet_To_Node_Valid,
   output logic              retry_fail,
   output logic              token_lost
);

   localparam bit IS_MASTER = (OUR_ADDRESS == 0);
   localparam int AT_W = $clog2(ACK_TIMEOUT + 1);
   localparam int TT_W = $clog2(TOKEN_TIMEOUT + 1);

   localparam logic [2:0] T_TOKEN = 3'b111;
   localparam logic [2:0] T_ACK   = 3'b000;
   localparam logic [2:0] T_NACK  = 3'b011;

   localparam logic [2:0] SEL_ACK   = 3'd0;
   localparam logic [2:0] SEL_NACK  = 3'd1;
   localparam logic [2:0] SEL_FWD   = 3'd2;
   localparam logic [2:0] SEL_TOKEN = 3'd3;
   localparam logic [2:0] SEL_NEW   = 3'd4;

   typedef enum logic [3:0] {
      S_INIT        = 4'd0,
      S_CHECK_NODE  = 4'd1,
      S_ENCODE      = 4'd2,
      S_SEND_TX     = 4'd3,
      S_LISTEN_TOK  = 4'd4,
      S_FAIL        = 4'd5,
      S_DONE        = 4'd6,
      S_SEND_TOKEN  = 4'd7,
      S_LISTEN_IDLE = 4'd8,
      S_CHECK_ADDR  = 4'd9,
      S_FORWARD     = 4'd10,
      S_SEND_NACK   = 4'd11,
      S_SEND_NODE   = 4'd12,
      S_BCAST       = 4'd13
   } state_t;

   state_t state_q, state_d;

   logic [CH_W-1:0]   grant_q, rr_q, pick, rr_nxt, idx;
   logic              found;
   logic [3:0]        retry_q;
   logic [AT_W-1:0]   ack_tmr_q;
   logic [TT_W-1:0]   idle_q;
   logic [2:0]        rx_type_q;
   logic [ADDR_W-1:0] rx_addr_q;
   logic              rx_bad_q;
   logic              tok_lost_q;
   logic              req_any, ack_tmo, tok_tmo;
   logic              retry_ok, rx_own, rx_bcast;

   assign req_any   = |Packet_From_Node_Valid;
   assign ack_tmo   = (ack_tmr_q == AT_W'(ACK_TIMEOUT - 1));
   assign tok_tmo   = IS_MASTER &&
                      (idle_q == TT_W'(TOKEN_TIMEOUT - 1));
   assign retry_ok  = (retry_q < 4'(MAX_RETRY));
   assign rx_own    = (rx_addr_q == ADDR_W'(OUR_ADDRESS));
   assign rx_bcast  = &rx_addr_q;
   assign ch_select = grant_q;
   assign token_lost = tok_lost_q;

   assign rr_nxt = (grant_q == CH_W'(NUM_CH - 1)) ?
                   '0 : grant_q + 1'b1;

   // First requester at or after the rr pointer, wrapping.
   always_comb begin
      pick  = rr_q;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = CH_W'((int'(rr_q) + i) % NUM_CH);
         if (!found && Packet_From_Node_Valid[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk_R) begin
      if (Rst) state_q <= S_INIT;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d              = state_q;
      Core_Load_Ack        = '0;
      tx_data_select       = 3'd0;
      rc_has_data          = 1'b0;
      rc_ready             = 1'b0;
      Packet_To_Node_Valid = 1'b0;
      retry_fail           = 1'b0;
      case (state_q)
         S_INIT:
            state_d = IS_MASTER ? S_CHECK_NODE : S_LISTEN_IDLE;
         S_CHECK_NODE: begin
            if (req_any)       state_d = S_ENCODE;
            else if (tx_ready) state_d = S_SEND_TOKEN;
         end
         S_ENCODE: begin
            tx_data_select = SEL_NEW;
            rc_has_data    = 1'b1;
            if (tx_ready) state_d = S_SEND_TX;
         end
         S_SEND_TX: begin
            // Node only sees the load once; retries resend from tx.
            if (retry_q == 4'd0)
               Core_Load_Ack = NUM_CH'(1) << grant_q;
            state_d = S_LISTEN_TOK;
         end
         S_LISTEN_TOK: begin
            rc_ready = 1'b1;
            if (rx_has_data) begin
               if (data_type == T_NACK)
                  state_d = retry_ok ? S_ENCODE : S_FAIL;
               else
                  state_d = S_DONE;
            end else if (ack_tmo) begin
               state_d = S_FAIL;
            end
         end
         S_FAIL: begin
            retry_fail = 1'b1;
            state_d    = S_DONE;
         end
         S_DONE:
            state_d = S_CHECK_NODE;
         S_SEND_TOKEN: begin
            tx_data_select = SEL_TOKEN;
            rc_has_data    = 1'b1;
            state_d        = S_LISTEN_IDLE;
         end
         S_LISTEN_IDLE: begin
            rc_ready = 1'b1;
            if (rx_has_data)  state_d = S_CHECK_ADDR;
            else if (tok_tmo) state_d = S_CHECK_NODE;
         end
         S_CHECK_ADDR: begin
            if (rx_type_q == T_TOKEN)
               state_d = S_CHECK_NODE;
            else if (rx_type_q == T_ACK || rx_type_q == T_NACK)
               state_d = S_FORWARD;
            else if (!rx_own && !rx_bcast)
               state_d = S_FORWARD;
            else if (rx_bad_q)
               state_d = S_SEND_NACK;
            else if (rx_own)
               state_d = S_SEND_NODE;
            else
               state_d = S_BCAST;
         end
         S_FORWARD: begin
            tx_data_select = SEL_FWD;
            rc_has_data    = 1'b1;
            state_d        = S_LISTEN_IDLE;
         end
         S_SEND_NACK: begin
            tx_data_select = SEL_NACK;
            rc_has_data    = 1'b1;
            state_d        = S_LISTEN_IDLE;
         end
         S_SEND_NODE: begin
            Packet_To_Node_Valid = 1'b1;
            tx_data_select       = SEL_ACK;
            rc_has_data          = 1'b1;
            state_d              = S_LISTEN_IDLE;
         end
         S_BCAST: begin
            Packet_To_Node_Valid = 1'b1;
            tx_data_select       = SEL_FWD;
            rc_has_data          = 1'b1;
            state_d              = S_LISTEN_IDLE;
         end
         default:
            state_d = S_INIT;
      endcase
   end

   always_ff @(posedge Clk_R) begin
      if (Rst) begin
         grant_q    <= '0;
         rr_q       <= '0;
         retry_q    <= '0;
         ack_tmr_q  <= '0;
         idle_q     <= '0;
         rx_type_q  <= '0;
         rx_addr_q  <= '0;
         rx_bad_q   <= 1'b0;
         tok_lost_q <= 1'b0;
      end else begin
         tok_lost_q <= 1'b0;
         case (state_q)
            S_CHECK_NODE: begin
               if (req_any) begin
                  grant_q <= pick;
                  retry_q <= '0;
               end
            end
            S_SEND_TX:
               ack_tmr_q <= '0;
            S_LISTEN_TOK: begin
               ack_tmr_q <= ack_tmr_q + 1'b1;
               if (rx_has_data && data_type == T_NACK && retry_ok)
                  retry_q <= retry_q + 4'd1;
            end
            S_DONE:
               rr_q <= rr_nxt;
            S_SEND_TOKEN:
               idle_q <= '0;
            S_LISTEN_IDLE: begin
               if (rx_has_data) begin
                  idle_q    <= '0;
                  rx_type_q <= data_type;
                  rx_addr_q <= address;
                  rx_bad_q  <= bad_decode;
               end else if (IS_MASTER) begin
                  if (tok_tmo) begin
                     tok_lost_q <= 1'b1;
                     idle_q     <= '0;
                  end else begin
                     idle_q <= idle_q + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
